window_stream_mult: RTL and testbench

//  Parametrised FMCW range-window multiplier. Sits between the ADC capture buffer and the FFT.

---
 rtl/radar_dsp_pkg.sv | 34 +++
 rtl/window_coef_ram.sv | 36 +++
 rtl/window_stream_mult.sv | 171 +++++++++++++++++
 tb/tb_window_stream_mult.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/radar_dsp_pkg.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | radar_dsp_pkg : shared state encodings and Q-format round/saturate      |
// | Revision      : 1.0                                                     |
// +-------------------------------------------------------------------------+
package radar_dsp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   localparam int ACC_W = 64;

   // Round half up by dropping FRAC_BITS fraction bits, then clamp to OUT_W signed bits.
   function automatic logic signed [ACC_W-1:0] round_sat(
      input logic signed [ACC_W-1:0] p,
      input int                      frac_bits,
      input int                      out_w
   );
      logic signed [ACC_W-1:0] r;
      logic signed [ACC_W-1:0] hi;
      logic signed [ACC_W-1:0] lo;
      r  = (p + (64'sd1 <<< (frac_bits - 1))) >>> frac_bits;
      hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
      lo = -(64'sd1 <<< (out_w - 1));
      if (r > hi)      return hi;
      else if (r < lo) return lo;
      else             return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/window_coef_ram.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | window_coef_ram : window coefficient store, 1 write / LANES sync reads  |
// | Revision        : 1.0                                                   |
// +-------------------------------------------------------------------------+
module window_coef_ram #(
   parameter int COEF_W = 12,
   parameter int DEPTH  = 1024,
   parameter int LANES  = 2,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [AW-1:0]           waddr,
   input  logic [COEF_W-1:0]       wdata,
   input  logic                    re,
   input  logic [LANES*AW-1:0]     raddr,
   output logic [LANES*COEF_W-1:0] rdata
);

   logic [COEF_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   for (genvar l = 0; l < LANES; l++) begin : g_rd
      logic [COEF_W-1:0] r_q;
      always_ff @(posedge clk) begin
         if (re) r_q <= mem[raddr[l*AW +: AW]];
      end
      assign rdata[l*COEF_W +: COEF_W] = r_q;
   end

endmodule
`default_nettype wire

// File: rtl/window_stream_mult.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | window_stream_mult : streaming FMCW range-window multiplier, 3 stages   |
// | Revision           : 1.0                                                |
// +-------------------------------------------------------------------------+
module window_stream_mult
   import radar_dsp_pkg::*;
#(
   parameter int DATA_W    = 12,
   parameter int COEF_W    = 12,
   parameter int FRAME_LEN = 2048,
   parameter int LANES     = 2,
   parameter int SYMMETRIC = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    s_valid,
   output logic                    s_ready,
   input  logic                    s_sof,
   input  logic [LANES*DATA_W-1:0] s_data,
   output logic                    m_valid,
   input  logic                    m_ready,
   output logic                    m_sof,
   output logic                    m_eof,
   output logic [LANES*DATA_W-1:0] m_data,
   input  logic                    bypass,
   input  logic                    cfg_we,
   input  logic [$clog2(FRAME_LEN/((SYMMETRIC != 0) ? 2 : 1))-1:0] cfg_addr,
   input  logic [COEF_W-1:0]       cfg_data,
   output logic                    frame_err,
   output logic [1:0]              state
);

   localparam int DEPTH = FRAME_LEN / ((SYMMETRIC != 0) ? 2 : 1);
   localparam int AW    = $clog2(DEPTH);
   localparam int BEATS = FRAME_LEN / LANES;
   localparam int BW    = $clog2(BEATS);
   localparam int NW    = $clog2(FRAME_LEN);
   localparam int PW    = DATA_W + COEF_W + 1;
   localparam logic [COEF_W-1:0] COEF_ONE = {1'b1, {(COEF_W-1){1'b0}}};

   state_t                    r_state;
   logic [BW-1:0]             r_beat;
   logic                      r_bypass;
   logic                      r_alive;
   logic                      r_s1_valid, r_s1_sof, r_s1_eof;
   logic [LANES*DATA_W-1:0]   r_s1_data;
   logic                      r_s2_valid, r_s2_sof, r_s2_eof;
   logic [LANES*AW-1:0]       w_raddr;
   logic [LANES*COEF_W-1:0]   w_rdata;

   logic          w_en, w_empty, w_acc, w_start, w_run_acc, w_load, w_last;
   logic          w_cfg_ok, w_err;
   logic [BW-1:0] w_idx;

   assign w_en      = m_ready | ~m_valid;
   assign w_empty   = ~r_s1_valid & ~r_s2_valid & ~m_valid;
   assign s_ready   = r_alive & (r_state != ST_DRAIN) & w_en;
   assign w_acc     = s_valid & s_ready;
   assign w_start   = w_acc & s_sof & (r_state == ST_IDLE);
   assign w_run_acc = w_acc & (r_state == ST_RUN);
   assign w_load    = w_start | w_run_acc;
   // A sof beat always restarts at beat 0, even mid-frame.
   assign w_idx     = ((r_state == ST_RUN) && !s_sof) ? r_beat : '0;
   assign w_last    = (w_idx == BW'(BEATS - 1));
   assign w_cfg_ok  = cfg_we & (r_state == ST_IDLE) & w_empty;
   assign w_err     = (w_acc & (r_state == ST_IDLE) & ~s_sof)
                    | (w_run_acc & s_sof)
                    | (cfg_we & ~w_cfg_ok);
   assign state     = r_state;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_beat    <= '0;
         r_bypass  <= 1'b0;
         r_alive   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         r_alive   <= 1'b1;
         frame_err <= w_err;
         case (r_state)
            ST_IDLE: if (w_start) begin
               r_bypass <= bypass;
               r_beat   <= BW'(1);
               r_state  <= ST_RUN;
            end
            ST_RUN: if (w_run_acc) begin
               if (w_last) begin
                  r_beat  <= '0;
                  r_state <= ST_DRAIN;
               end else begin
                  r_beat  <= w_idx + BW'(1);
               end
            end
            ST_DRAIN: if (w_empty) r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s1_valid <= 1'b0;
         r_s1_sof   <= 1'b0;
         r_s1_eof   <= 1'b0;
         r_s1_data  <= '0;
         r_s2_valid <= 1'b0;
         r_s2_sof   <= 1'b0;
         r_s2_eof   <= 1'b0;
         m_valid    <= 1'b0;
         m_sof      <= 1'b0;
         m_eof      <= 1'b0;
      end else if (w_en) begin
         r_s1_valid <= w_load;
         r_s1_sof   <= w_load & (w_idx == '0);
         r_s1_eof   <= w_load & w_last;
         r_s1_data  <= s_data;
         r_s2_valid <= r_s1_valid;
         r_s2_sof   <= r_s1_sof;
         r_s2_eof   <= r_s1_eof;
         m_valid    <= r_s2_valid;
         m_sof      <= r_s2_valid & r_s2_sof;
         m_eof      <= r_s2_valid & r_s2_eof;
      end
   end

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [NW-1:0]        w_n;
      logic [COEF_W-1:0]    w_coef;
      logic signed [PW-1:0] w_prod;
      logic signed [PW-1:0] r_prod;
      logic [DATA_W-1:0]    r_out;

      assign w_n = NW'(int'(w_idx) * LANES + l);
      // FRAME_LEN-1-n equals ~n because FRAME_LEN is a power of two.
      assign w_raddr[l*AW +: AW] = AW'(((SYMMETRIC != 0) && w_n[NW-1]) ? ~w_n : w_n);
      assign w_coef = r_bypass ? COEF_ONE : w_rdata[l*COEF_W +: COEF_W];
      assign w_prod = PW'($signed(r_s1_data[l*DATA_W +: DATA_W]))
                    * PW'($signed({1'b0, w_coef}));

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            r_prod <= '0;
            r_out  <= '0;
         end else if (w_en) begin
            r_prod <= w_prod;
            r_out  <= DATA_W'(round_sat(ACC_W'(r_prod), COEF_W - 1, DATA_W));
         end
      end

      assign m_data[l*DATA_W +: DATA_W] = r_out;
   end

   window_coef_ram #(
      .COEF_W (COEF_W),
      .DEPTH  (DEPTH),
      .LANES  (LANES),
      .AW     (AW)
   ) u_coef_ram (
      .clk   (clk),
      .we    (w_cfg_ok),
      .waddr (cfg_addr),
      .wdata (cfg_data),
      .re    (w_en),
      .raddr (w_raddr),
      .rdata (w_rdata)
   );

endmodule
`default_nettype wire

// File: tb/tb_window_stream_mult.sv
`default_nettype none
// +-------------------------------------------------------------------------+
// | tb_window_stream_mult : random-stimulus bench, SYMMETRIC=0 and =1 DUTs  |
// | Revision              : 1.0                                             |
// +-------------------------------------------------------------------------+
module tb_window_stream_mult;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_valid, s_sof, m_ready, bypass, cfg_we0, cfg_we1;
   logic [23:0] s_data;
   logic [10:0] cfg_addr;
   logic [11:0] cfg_data;

   logic        s_ready0, m_valid0, m_sof0, m_eof0, frame_err0;
   logic        s_ready1, m_valid1, m_sof1, m_eof1, frame_err1;
   logic [23:0] m_data0, m_data1;
   logic [1:0]  state0, state1;

   typedef struct packed {logic sof; logic eof; logic [23:0] d;} exp_t;
   exp_t q0[$];
   exp_t q1[$];
   int   c0[2048];
   int   c1[1024];
   bit   mdl_in_frame, mdl_byp, bp;
   int   mdl_idx;
   int   exp_err0, exp_err1, err_seen0, err_seen1;
   int   n_checks, n_errors;

   always #5 clk = ~clk;

   window_stream_mult #(.DATA_W(12), .COEF_W(12), .FRAME_LEN(2048), .LANES(2), .SYMMETRIC(0)) u_sym0 (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready0), .s_sof(s_sof),
      .s_data(s_data), .m_valid(m_valid0), .m_ready(m_ready), .m_sof(m_sof0), .m_eof(m_eof0),
      .m_data(m_data0), .bypass(bypass), .cfg_we(cfg_we0), .cfg_addr(cfg_addr),
      .cfg_data(cfg_data), .frame_err(frame_err0), .state(state0));

   window_stream_mult #(.DATA_W(12), .COEF_W(12), .FRAME_LEN(2048), .LANES(2), .SYMMETRIC(1)) u_sym1 (
      .clk(clk), .rst_n(rst_n), .s_valid(s_valid), .s_ready(s_ready1), .s_sof(s_sof),
      .s_data(s_data), .m_valid(m_valid1), .m_ready(m_ready), .m_sof(m_sof1), .m_eof(m_eof1),
      .m_data(m_data1), .bypass(bypass), .cfg_we(cfg_we1), .cfg_addr(cfg_addr[9:0]),
      .cfg_data(cfg_data), .frame_err(frame_err1), .state(state1));

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] expv);
      n_checks++;
      if (got !== expv) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, expv, $time);
      end
   endtask

   // Windowed sample from the arithmetic definition: floor((s*c + 2^10) / 2^11), clamped.
   function automatic logic [11:0] ref_win(input int s, input int c);
      longint r;
      r = (longint'(s) * longint'(c) + 64'sd1024) >>> 11;
      if (r > 2047)  r = 2047;
      if (r < -2048) r = -2048;
      return 12'(r);
   endfunction

   function automatic void model_beat(input bit sof, input logic [23:0] data);
      exp_t e0, e1;
      int   n, s;
      logic signed [11:0] sv;
      if (sof) begin
         if (mdl_in_frame) begin exp_err0++; exp_err1++; end
         else mdl_byp = bypass;
         mdl_in_frame = 1;
         mdl_idx      = 0;
      end else if (!mdl_in_frame) begin
         exp_err0++; exp_err1++;
         return;
      end
      e0 = '0; e1 = '0;
      for (int l = 0; l < 2; l++) begin
         n  = mdl_idx * 2 + l;
         sv = data[l*12 +: 12];
         s  = int'(sv);
         e0.d[l*12 +: 12] = ref_win(s, mdl_byp ? 2048 : c0[n]);
         e1.d[l*12 +: 12] = ref_win(s, mdl_byp ? 2048 : c1[(n < 1024) ? n : 2047 - n]);
      end
      e0.sof = (mdl_idx == 0);  e0.eof = (mdl_idx == 1023);
      e1.sof = e0.sof;          e1.eof = e0.eof;
      q0.push_back(e0);
      q1.push_back(e1);
      if (mdl_idx == 1023) mdl_in_frame = 0;
      else mdl_idx++;
   endfunction

   always @(negedge clk) begin
      if (rst_n) begin
         if (m_valid0 && m_ready) begin
            if (q0.size() == 0) check_val("unexpected_out0", 1, 0);
            else check_val("out0", {6'd0, m_sof0, m_eof0, m_data0}, {6'd0, q0.pop_front()});
         end
         if (m_valid1 && m_ready) begin
            if (q1.size() == 0) check_val("unexpected_out1", 1, 0);
            else check_val("out1", {6'd0, m_sof1, m_eof1, m_data1}, {6'd0, q1.pop_front()});
         end
         if (m_valid0 && !m_ready) check_val("s_ready_stalled", {31'd0, s_ready0}, 0);
         if (frame_err0) err_seen0++;
         if (frame_err1) err_seen1++;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      s_valid = 0; s_sof = 0; cfg_we0 = 0; cfg_we1 = 0;
      m_ready = bp ? ($urandom_range(0, 99) < 30) : 1'b1;
   endtask

   task automatic drive_beat(input bit sof, input logic [23:0] data);
      bit acc = 0;
      int tries = 0;
      while (!acc) begin
         tick();
         s_valid = 1; s_sof = sof; s_data = data;
         @(negedge clk);
         if (s_ready0) begin
            acc = 1;
            model_beat(sof, data);
         end
         tries++;
         if (!acc && tries > 2000) begin
            check_val("accept_timeout", 0, 1);
            break;
         end
      end
   endtask

   task automatic send_frame(input bit rnd, input int nbeats, input bit first_sof);
      for (int b = 0; b < nbeats; b++)
         drive_beat(first_sof && b == 0, rnd ? 24'($urandom) : {12'd1024, 12'd1024});
   endtask

   task automatic cfg_write(input bit we0, input bit we1, input int addr, input int data, input bit ok);
      tick();
      cfg_we0 = we0; cfg_we1 = we1; cfg_addr = 11'(addr); cfg_data = 12'(data);
      if (ok) begin
         if (we0) c0[addr] = data & 12'hFFF;
         if (we1) c1[addr % 1024] = data & 12'hFFF;
      end else begin
         if (we0) exp_err0++;
         if (we1) exp_err1++;
      end
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin tick(); n++; end
      while ((q0.size() != 0 || q1.size() != 0 || state0 != 2'd0) && n < 8000);
      if (n >= 8000) check_val("drain_timeout", 0, 1);
      tick(); tick();
      check_val("frame_err_count0", err_seen0, exp_err0);
      check_val("frame_err_count1", err_seen1, exp_err1);
   endtask

   task automatic check_reset_outputs();
      check_val("rst_m_valid0", {31'd0, m_valid0}, 0);
      check_val("rst_m_valid1", {31'd0, m_valid1}, 0);
      check_val("rst_m_data0", {8'd0, m_data0}, 0);
      check_val("rst_m_sof_eof0", {30'd0, m_sof0, m_eof0}, 0);
      check_val("rst_frame_err0", {31'd0, frame_err0}, 0);
      check_val("rst_state0", {30'd0, state0}, 0);
      check_val("rst_state1", {30'd0, state1}, 0);
      check_val("rst_s_ready0", {31'd0, s_ready0}, 0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", n_checks, n_errors);
      $fatal(1, "watchdog");
   end

   initial begin
      int v;
      n_checks = 0; n_errors = 0; exp_err0 = 0; exp_err1 = 0; err_seen0 = 0; err_seen1 = 0;
      mdl_in_frame = 0; mdl_idx = 0; mdl_byp = 0; bp = 0;
      rst_n = 0; s_valid = 0; s_sof = 0; s_data = '0; m_ready = 1; bypass = 0;
      cfg_we0 = 0; cfg_we1 = 0; cfg_addr = '0; cfg_data = '0;
      repeat (3) @(posedge clk);
      #1;
      check_reset_outputs();
      rst_n = 1;

      // Ramp coefficients coef[k] = k in both DUTs.
      for (int k = 0; k < 2048; k++) cfg_write(1, k < 1024, k, k, 1);

      // Unity window via bypass.
      bypass = 1;
      send_frame(0, 1024, 1);
      wait_idle();
      bypass = 0;

      // Ramp window, constant input: linear on DUT0, mirrored on DUT1.
      send_frame(0, 1024, 1);
      wait_idle();

      // Random coefficients with full-scale ones at the start for saturation.
      for (int k = 0; k < 2048; k++) begin
         v = (k < 6) ? 4095 : int'($urandom_range(0, 4095));
         cfg_write(1, k < 1024, k, v, 1);
      end
      drive_beat(1, {12'h800, 12'h7FF});
      drive_beat(0, {12'h7FF, 12'hFFF});
      send_frame(1, 1022, 0);
      wait_idle();

      // Backpressure at 30% m_ready duty.
      bp = 1;
      send_frame(1, 1024, 1);
      wait_idle();
      bp = 0;

      // Framing: dropped non-sof beat, ignored cfg write, mid-frame sof at beat 500.
      drive_beat(0, 24'($urandom));
      send_frame(1, 300, 1);
      cfg_write(1, 0, 5, 0, 0);
      send_frame(1, 200, 0);
      send_frame(1, 1024, 1);
      wait_idle();

      // Asynchronous reset mid-frame, then a clean frame under backpressure.
      bp = 1;
      send_frame(1, 300, 1);
      tick();
      rst_n = 0;
      q0.delete();
      q1.delete();
      mdl_in_frame = 0;
      #1;
      check_reset_outputs();
      tick(); tick();
      rst_n = 1;
      send_frame(1, 1024, 1);
      wait_idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
